// File: rtl/rf_riscv_sb.sv
// rf_riscv_sb: parametrised 2R/1W register file with pending-write scoreboard
// and a one-entry-per-cycle clear sequencer.
//   clk_i, rst_ni           clock, async active-low reset
//   write_enable_i/addr/data writeback port (dropped while sweeping)
//   read_addr{1,2}_i         combinational read ports -> read_data{1,2}_o
//   issue_i/issue_addr_i     mark a destination register as pending
//   pend{1,2}_o              pending status of the read addresses (comb)
//   clear_i                  start a full-array clear sweep
//   ready_o                  registered, low while a sweep is running
module rf_riscv_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     write_enable_i,
  input  logic [$clog2(NREGS)-1:0] write_addr_i,
  input  logic [XLEN-1:0]          write_data_i,
  input  logic [$clog2(NREGS)-1:0] read_addr1_i,
  input  logic [$clog2(NREGS)-1:0] read_addr2_i,
  output logic [XLEN-1:0]          read_data1_o,
  output logic [XLEN-1:0]          read_data2_o,
  input  logic                     issue_i,
  input  logic [$clog2(NREGS)-1:0] issue_addr_i,
  output logic                     pend1_o,
  output logic                     pend2_o,
  input  logic                     clear_i,
  output logic                     ready_o
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam bit          ZR = (ZERO_REG != 0);
  localparam bit          BP = (BYPASS != 0);

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   rf_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;

  logic idle, sweep_we, clr_pend, wr_ok, iss_ok;
  logic hit1, hit2, zero1, zero2;

  // Qualified write/issue: only honoured in IDLE, never to a hard-wired zero register
  assign idle   = (state_q == S_IDLE);
  assign wr_ok  = idle && write_enable_i && !(ZR && (write_addr_i == '0));
  assign iss_ok = idle && issue_i && !(ZR && (issue_addr_i == '0));

  // Same-cycle write forwarding, disabled while sweeping
  assign hit1  = BP && idle && write_enable_i && (write_addr_i == read_addr1_i);
  assign hit2  = BP && idle && write_enable_i && (write_addr_i == read_addr2_i);
  assign zero1 = ZR && (read_addr1_i == '0);
  assign zero2 = ZR && (read_addr2_i == '0);

  assign read_data1_o = zero1 ? '0 : (hit1 ? write_data_i : rf_q[read_addr1_i]);
  assign read_data2_o = zero2 ? '0 : (hit2 ? write_data_i : rf_q[read_addr2_i]);

  // A bypassed write already resolves the hazard, so pending is masked
  assign pend1_o = idle && !zero1 && !hit1 && pend_q[read_addr1_i];
  assign pend2_o = idle && !zero2 && !hit2 && pend_q[read_addr2_i];

  assign ready_o = ready_q;

  // State register, sweep counter and registered ready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear_i) state_d = S_SWEEP;
      S_SWEEP: if (cnt_q == AW'(NREGS - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath control decoded from state
  always_comb begin
    ready_d  = (state_d == S_IDLE);
    sweep_we = 1'b0;
    clr_pend = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear_i) begin
          clr_pend = 1'b1;
          cnt_d    = '0;
        end
      end
      S_SWEEP: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + AW'(1);
      end
      default: ;
    endcase
  end

  // Scoreboard update: clear-all first, then writeback clear, issue set wins
  always_comb begin
    pend_d = pend_q;
    if (clr_pend) pend_d = '0;
    if (wr_ok)    pend_d[write_addr_i] = 1'b0;
    if (iss_ok)   pend_d[issue_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  // Register array: sweep clear has priority over (already blocked) writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (sweep_we) begin
      rf_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      rf_q[write_addr_i] <= write_data_i;
    end
  end

endmodule

// File: doc/rf_riscv_sb.md
# rf_riscv_sb

Parametrised successor to the 2R/1W RISC-V register file. It adds configurable data width and depth, an optional hard-wired zero register, and optional write-to-read bypass. It also carries a per-register pending-write scoreboard and a runtime clear sequencer that zeroes the array one entry per cycle. It sits between decode (read ports, scoreboard issue) and writeback (write port) in the pipelined core.

## Interface
Parameters:
- `XLEN`, 32: register data width.
- `NREGS`, 32: number of registers, power of two ≥ 2. `AW = $clog2(NREGS)`.
- `ZERO_REG`, 1: if 1, register 0 reads as 0, ignores writes and never becomes pending.
- `BYPASS`, 1: if 1, a same-cycle write is forwarded to the read ports.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `write_enable_i` in 1: writeback strobe.
- `write_addr_i` in AW: writeback register index.
- `write_data_i` in XLEN: writeback data.
- `read_addr1_i` in AW: read port 1 index.
- `read_addr2_i` in AW: read port 2 index.
- `read_data1_o` out XLEN: read port 1 data, combinational.
- `read_data2_o` out XLEN: read port 2 data, combinational.
- `issue_i` in 1: marks `issue_addr_i` as pending a future write.
- `issue_addr_i` in AW: destination register of the issued instruction.
- `pend1_o` out 1: register at `read_addr1_i` is pending, combinational.
- `pend2_o` out 1: register at `read_addr2_i` is pending, combinational.
- `clear_i` in 1: request a full-array clear sweep.
- `ready_o` out 1: 1 when idle; 0 while a sweep is in progress.

## Operation
- Reset (`rst_ni`=0, asynchronous):
  - all registers = 0, all pending bits = 0.
  - FSM = IDLE, sweep counter = 0, `ready_o` = 1.
- Write: in IDLE, `write_enable_i`=1 stores `write_data_i` to `write_addr_i` at the edge. Index 0 is dropped when `ZERO_REG`=1.
- Read `readN_data_o`:
  - 0 if `ZERO_REG` and address is 0;
  - else `write_data_i` if `BYPASS`, IDLE, `write_enable_i`, and `write_addr_i` equals the read address;
  - else array contents.
- Scoreboard, per register, applied at the edge in IDLE:
  - `issue_i` sets `pending[issue_addr_i]`.
  - `write_enable_i` clears `pending[write_addr_i]`.
  - Set and clear on the same index in the same cycle: set wins (a newer writer was issued).
  - Index 0 is never set when `ZERO_REG`=1.
- `pendN_o` = `pending[addr]`. When `BYPASS`=1 it is forced to 0 if the same-cycle write targets that address. It is always 0 for index 0 when `ZERO_REG`=1.
- FSM states:
  - IDLE → SWEEP when `clear_i`=1. On that same edge all pending bits clear and the counter loads 0. A write or issue presented in that cycle is still performed.
  - SWEEP: each edge writes 0 to `rf[cnt]` and increments `cnt`.
  - SWEEP → IDLE on the edge that writes `cnt`=NREGS-1; the counter wraps to 0.
- During SWEEP:
  - `write_enable_i`, `issue_i` and `clear_i` are ignored and dropped.
  - Bypass is disabled.
  - Reads return current array contents (partially cleared).
  - `pendN_o` = 0.
- Reset asserted mid-sweep aborts it immediately: state goes to IDLE, with registers and pending bits zeroed by reset.

## Timing
- Read latency: 0 cycles (combinational from address, and from write inputs when bypass is active).
- Write visible on non-bypassed reads on the cycle after the edge.
- `ready_o` is a registered output. It falls the cycle after `clear_i` is accepted and stays low for exactly NREGS cycles. `write_enable_i` is honoured again on the first cycle with `ready_o`=1.
- Pending bit set by `issue_i` in cycle N is visible on `pendN_o` in cycle N+1.

## Test plan
- **Reset and zero register.** Release reset, then write 0xDEADBEEF to reg 0 and 0x12345678 to reg 5. Required: reg 0 reads 0, reg 5 reads 0x12345678 from the next cycle. `ready_o`=1 throughout.
- **Bypass.** `BYPASS`=1: write 0xA5A5A5A5 to reg 7 while `read_addr1_i`=7. Required: `read_data1_o`=0xA5A5A5A5 in the same cycle. With `BYPASS`=0, the old value is shown until the next cycle.
- **Scoreboard.**
  - Issue reg 3 → `pend1_o`=1 next cycle (addr1=3).
  - Write reg 3 → `pend1_o`=0 in the same cycle when `BYPASS`=1.
  - Issue and write reg 3 in the same cycle → stays pending.
- **Clear sweep.** Fill all NREGS registers with nonzero values, pulse `clear_i`. Required:
  - `ready_o` low for exactly NREGS cycles;
  - all registers read 0 afterwards;
  - a write issued mid-sweep is lost;
  - all pending bits are 0.
- **Reset mid-sweep.** Assert `rst_ni`=0 at cycle NREGS/2 of a sweep. Required: `ready_o`=1 immediately, all reads 0, normal writes succeed after release.
- **Parameter sweep.** `XLEN`=64, `NREGS`=16, `ZERO_REG`=0: write 0xFFFF_FFFF_0000_0001 to reg 0 and reg 15. Required: both read back exactly, and a sweep takes 16 cycles.
